emergency_monitor: RTL and testbench

Parametrised, clocked successor to the combinational emergency logic. It supports configurable tap and appliance counts, a persistence filter on the water-leak and gas-meter conditions, latched `warning_o`/`alert_o` outputs that stay set until acknowledged, and optional saturating event counters. It sits between the home sensor inputs and the annunciator/notification logic and replaces the purely combinational path.

---
 rtl/emergency_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_emergency_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_monitor.sv
// ---------------------------------------------------------------------------
// emergency_monitor
//
// Clocked home emergency monitor. Two independent FSMs watch for a water
// leak (water flowing at the meter while every tap is closed) and a gas
// hazard (gas flowing with no consumer running, or gas detected in the air).
// The meter-derived conditions must persist for PERSIST_CYCLES consecutive
// cycles before they latch. The detector condition latches on the next edge.
// Latched outputs hold until ack_i arrives while the cause has gone away.
//
// Optional feature macro: EMERGENCY_EVENT_COUNT_EN
//   defined   -> 8-bit saturating counts of WARN / ALERT entries
//   undefined -> counters not built, count outputs tied to zero
//
// Ports:
//   clk_i                      clock, rising edge
//   rst_i                      synchronous active-high reset
//   emergency_control_valid_i  monitoring enable; low forces all raw conditions false
//   water_meter_status_i       water flowing at the meter
//   home_tap_status_i          [NUM_TAPS]   1 = tap open
//   gas_meter_i                gas flowing at the meter
//   gas_detector_i             gas detected in the air
//   stove_status_i             [NUM_STOVES] 1 = burner on
//   ac_system_status_i         [NUM_AC]     1 = gas-fired AC running
//   ack_i                      user acknowledge pulse
//   warning_o                  latched water-leak warning
//   alert_o                    latched gas alert
//   warn_count_o               [8] WARN entries, saturating
//   alert_count_o              [8] ALERT entries, saturating
// ---------------------------------------------------------------------------
module emergency_monitor #(
  parameter int NUM_TAPS       = 8,
  parameter int NUM_STOVES     = 2,
  parameter int NUM_AC         = 1,
  parameter int PERSIST_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  emergency_control_valid_i,
  input  logic                  water_meter_status_i,
  input  logic [NUM_TAPS-1:0]   home_tap_status_i,
  input  logic                  gas_meter_i,
  input  logic                  gas_detector_i,
  input  logic [NUM_STOVES-1:0] stove_status_i,
  input  logic [NUM_AC-1:0]     ac_system_status_i,
  input  logic                  ack_i,
  output logic                  warning_o,
  output logic                  alert_o,
  output logic [7:0]            warn_count_o,
  output logic [7:0]            alert_count_o
);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ARMING = 2'd1,
    W_WARN   = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_ARMING = 2'd1,
    G_ALERT  = 2'd2
  } g_state_e;

  // Count value on which the final qualifying edge lands; with a single
  // persistence cycle IDLE jumps straight to the latched state instead.
  localparam logic [7:0] PERSIST_LAST = 8'(PERSIST_CYCLES - 1);
  localparam bit         PERSIST_ONE  = (PERSIST_CYCLES == 1);

  logic raw_w, raw_gm, raw_gd;

  w_state_e   w_state_q, w_state_d;
  g_state_e   g_state_q, g_state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] gcnt_q, gcnt_d;

  // Raw conditions
  always_comb begin
    raw_w  = emergency_control_valid_i & water_meter_status_i & ~(|home_tap_status_i);
    raw_gm = emergency_control_valid_i & gas_meter_i
             & ~((|stove_status_i) | (|ac_system_status_i));
    raw_gd = emergency_control_valid_i & gas_detector_i;
  end

  // Water FSM next state
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (raw_w && PERSIST_ONE) begin
          w_state_d = W_WARN;
        end else if (raw_w) begin
          w_state_d = W_ARMING;
          wcnt_d    = 8'd1;
        end
      end
      W_ARMING: begin
        if (!raw_w) begin
          w_state_d = W_IDLE;
          wcnt_d    = 8'd0;
        end else if (wcnt_q == PERSIST_LAST) begin
          w_state_d = W_WARN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      W_WARN: begin
        // An acknowledge while the leak is still present is ignored.
        if (ack_i && !raw_w) begin
          w_state_d = W_IDLE;
          wcnt_d    = 8'd0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        wcnt_d    = 8'd0;
      end
    endcase
  end

  // Gas FSM next state; the detector bypasses persistence entirely
  always_comb begin
    g_state_d = g_state_q;
    gcnt_d    = gcnt_q;
    case (g_state_q)
      G_IDLE: begin
        if (raw_gd || (raw_gm && PERSIST_ONE)) begin
          g_state_d = G_ALERT;
        end else if (raw_gm) begin
          g_state_d = G_ARMING;
          gcnt_d    = 8'd1;
        end
      end
      G_ARMING: begin
        if (raw_gd) begin
          g_state_d = G_ALERT;
        end else if (!raw_gm) begin
          g_state_d = G_IDLE;
          gcnt_d    = 8'd0;
        end else if (gcnt_q == PERSIST_LAST) begin
          g_state_d = G_ALERT;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      G_ALERT: begin
        if (ack_i && !raw_gm && !raw_gd) begin
          g_state_d = G_IDLE;
          gcnt_d    = 8'd0;
        end
      end
      default: begin
        g_state_d = G_IDLE;
        gcnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      g_state_q <= G_IDLE;
      wcnt_q    <= 8'd0;
      gcnt_q    <= 8'd0;
    end else begin
      w_state_q <= w_state_d;
      g_state_q <= g_state_d;
      wcnt_q    <= wcnt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Outputs decode directly from the state registers, so they are glitch-free.
  assign warning_o = (w_state_q == W_WARN);
  assign alert_o   = (g_state_q == G_ALERT);

`ifdef EMERGENCY_EVENT_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] warn_cnt_q, warn_cnt_d;
  logic [7:0] alert_cnt_q, alert_cnt_d;

  // Count entries into the latched state, not cycles spent there.
  always_comb begin
    warn_cnt_d  = warn_cnt_q;
    alert_cnt_d = alert_cnt_q;
    if ((w_state_q != W_WARN) && (w_state_d == W_WARN)) begin
      warn_cnt_d = sat_inc(warn_cnt_q);
    end
    if ((g_state_q != G_ALERT) && (g_state_d == G_ALERT)) begin
      alert_cnt_d = sat_inc(alert_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warn_cnt_q  <= 8'd0;
      alert_cnt_q <= 8'd0;
    end else begin
      warn_cnt_q  <= warn_cnt_d;
      alert_cnt_q <= alert_cnt_d;
    end
  end

  assign warn_count_o  = warn_cnt_q;
  assign alert_count_o = alert_cnt_q;
`else
  assign warn_count_o  = 8'd0;
  assign alert_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_emergency_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for emergency_monitor (PERSIST_CYCLES=4, 8 taps, 2 stoves, 1 AC).
// Directed scenarios followed by randomized stimulus. A reference model
// tracks run lengths of qualifying cycles and latched flags; each expected
// output set is queued by the driver and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_emergency_monitor;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       wmeter = 1'b0;
  logic [7:0] taps = 8'h00;
  logic       gmeter = 1'b0;
  logic       gdet = 1'b0;
  logic [1:0] stove = 2'b00;
  logic [0:0] ac = 1'b0;
  logic       ack = 1'b0;
  logic       warning, alert;
  logic [7:0] warn_count, alert_count;

  emergency_monitor #(
    .NUM_TAPS(8), .NUM_STOVES(2), .NUM_AC(1), .PERSIST_CYCLES(P)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .emergency_control_valid_i (valid),
    .water_meter_status_i      (wmeter),
    .home_tap_status_i         (taps),
    .gas_meter_i               (gmeter),
    .gas_detector_i            (gdet),
    .stove_status_i            (stove),
    .ac_system_status_i        (ac),
    .ack_i                     (ack),
    .warning_o                 (warning),
    .alert_o                   (alert),
    .warn_count_o              (warn_count),
    .alert_count_o             (alert_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       a;
    logic [7:0] wc;
    logic [7:0] ac;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int run_w = 0, run_g = 0;
  bit lat_w = 0, lat_g = 0;
  int cnt_w = 0, cnt_a = 0;

  task automatic model_edge(input bit r, v, wm, input logic [7:0] tp, input bit gm, gd,
                            input logic [1:0] st, input bit acs, ak);
    bit rw, rgm, rgd;
    rw  = v && wm && (tp == 8'h00);
    rgm = v && gm && (st == 2'b00) && !acs;
    rgd = v && gd;
    if (r) begin
      run_w = 0; run_g = 0; lat_w = 0; lat_g = 0; cnt_w = 0; cnt_a = 0;
      return;
    end
    if (lat_w) begin
      if (ak && !rw) begin lat_w = 0; run_w = 0; end
    end else begin
      run_w = rw ? run_w + 1 : 0;
      if (run_w >= P) begin
        lat_w = 1; run_w = 0;
        if (cnt_w < 255) cnt_w++;
      end
    end
    if (lat_g) begin
      if (ak && !rgm && !rgd) begin lat_g = 0; run_g = 0; end
    end else begin
      run_g = rgm ? run_g + 1 : 0;
      if (rgd || run_g >= P) begin
        lat_g = 1; run_g = 0;
        if (cnt_a < 255) cnt_a++;
      end
    end
  endtask

  task automatic step(input bit v, wm, input logic [7:0] tp, input bit gm, gd,
                      input logic [1:0] st, input bit acs, ak, r);
    exp_t e;
    @(negedge clk);
    valid = v; wmeter = wm; taps = tp; gmeter = gm; gdet = gd;
    stove = st; ac = acs; ack = ak; rst = r;
    model_edge(r, v, wm, tp, gm, gd, st, acs, ak);
    e.w = lat_w;
    e.a = lat_g;
`ifdef EMERGENCY_EVENT_COUNT_EN
    e.wc = 8'(cnt_w);
    e.ac = 8'(cnt_a);
`else
    e.wc = 8'd0;
    e.ac = 8'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic ack_all();
    step(1, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
  endtask

  // Monitor: every post-edge sample is a DUT output to score.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (warning !== e.w) begin
          n_fail++;
          $display("FAIL warning_o at %0t: got %b expected %b", $time, warning, e.w);
        end
        n_checks++;
        if (alert !== e.a) begin
          n_fail++;
          $display("FAIL alert_o at %0t: got %b expected %b", $time, alert, e.a);
        end
        n_checks++;
        if (warn_count !== e.wc) begin
          n_fail++;
          $display("FAIL warn_count_o at %0t: got %0d expected %0d", $time, warn_count, e.wc);
        end
        n_checks++;
        if (alert_count !== e.ac) begin
          n_fail++;
          $display("FAIL alert_count_o at %0t: got %0d expected %0d", $time, alert_count, e.ac);
        end
      end
    end
  end

  initial begin
    int budget;
    // Reset state
    step(0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 1);
    idle(2);

    // 1. Water persistence, then a 3-cycle run that is broken by an open tap
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 8'h01, 0, 0, 2'b00, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 8'h01, 0, 0, 2'b00, 0, 0, 0);

    // 2. Ack ignored while the leak persists, honoured once a tap opens
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 8'h00, 0, 0, 2'b00, 0, 1, 0);
    step(1, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 8'h10, 0, 0, 2'b00, 0, 1, 0);
    idle(2);

    // 3. Gas meter path, blocked by a running stove, and the detector bypass
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    ack_all();
    for (int i = 0; i < 8; i++) step(1, 0, 8'h00, 1, 0, 2'b10, 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0);
    idle(3);
    ack_all();
    idle(1);

    // 4. Valid gating, then dropping valid while WARN is latched
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 1, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    step(0, 1, 8'h00, 0, 0, 2'b00, 0, 1, 0);
    idle(1);

    // 5. Both latched, one ack clears both; then reset mid-ARMING
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    ack_all();
    for (int i = 0; i < 2; i++) step(1, 1, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    step(1, 1, 8'h00, 1, 0, 2'b00, 0, 0, 1);
    idle(4);

    // 6. Detector pulse / ack sequences drive the alert counter into saturation
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0);
      ack_all();
    end

    // Randomized traffic biased toward qualifying conditions
    for (int i = 0; i < 3000; i++) begin
      bit         v, wm, gm, gd, acs, ak, r;
      logic [7:0] tp;
      logic [1:0] st;
      v   = ($urandom_range(0, 9) != 0);
      wm  = ($urandom_range(0, 9) < 8);
      tp  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      gm  = ($urandom_range(0, 9) < 7);
      gd  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      acs = ($urandom_range(0, 7) == 0);
      ak  = ($urandom_range(0, 5) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(v, wm, tp, gm, gd, st, acs, ak, r);
    end
    idle(2);

    // Drain the scoreboard with a bounded wait
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
